sram22_port_ctrl: RTL and testbench
===================================

// Module: sram22_port_ctrl
// PURPOSE
//  Sequencer/arbiter in front of one SRAM22 single-port macro (64x4, wmask 2).
//  After reset it zero-fills the whole array, then shares the single port
//  between two requesters (port 0, port 1) with round-robin arbitration.
//  Read data is returned on a per-port response channel.
//  The macro sits beside this block; clk is shared, and the sae_int->sae_muxed loop is tied at top level.
// PARAMETERS
//  DATA_WIDTH   4   macro word width
//  ADDR_WIDTH   6   macro address width; depth = 1<<ADDR_WIDTH
//  WMASK_WIDTH  2   write-mask bits; each covers DATA_WIDTH/WMASK_WIDTH bits
// PORTS
//  clk          in   1            clock (same clk as macro)
//  rst          in   1            synchronous, active-high reset
//  init_done    out  1            1 once zero-fill complete
//  req_valid    in   2            [i] port i request valid
//  req_ready    out  2            [i] port i request accepted this cycle
//  req_we       in   2            [i] 1=write, 0=read
//  req_wmask    in   2*WMASK_WIDTH  port i mask at [i*WMASK_WIDTH +: WMASK_WIDTH]
//  req_addr     in   2*ADDR_WIDTH   port i address, packed likewise
//  req_din      in   2*DATA_WIDTH   port i write data, packed likewise
//  rsp_valid    out  2            [i] read data for port i valid this cycle
//  rsp_dout     out  DATA_WIDTH   read data (shared; qualify with rsp_valid)
//  sram_we      out  1            to macro we
//  sram_wmask   out  WMASK_WIDTH  to macro wmask
//  sram_addr    out  ADDR_WIDTH   to macro addr
//  sram_din     out  DATA_WIDTH   to macro din
//  sram_dout    in   DATA_WIDTH   from macro dout (registered inside macro)
// BEHAVIOUR
//  - States: INIT, RUN. Reset (any cycle, incl. mid-fill or mid-read) -> INIT,
//    init_cnt=0, rr_ptr=0, init_done=0, rsp_valid=0; in-flight response dropped.
//  - INIT: sram_we=1, sram_wmask=all ones, sram_addr=init_cnt, sram_din=0;
//    req_ready=0. init_cnt increments each cycle; on the cycle with
//    init_cnt==RAM_DEPTH-1 the next state is RUN. Fill takes exactly RAM_DEPTH
//    cycles; init_done=1 from the first RUN cycle until reset.
//  - RUN grant (combinational from req_valid): one valid -> grant it; both
//    valid -> grant rr_ptr; none -> no grant. req_ready = one-hot grant, and
//    req_ready may depend on req_valid. A handshake is valid&ready in the same
//    cycle.
//  - rr_ptr: after any grant rr_ptr <= ~granted_id; unchanged when idle.
//  - Granted request drives sram_* combinationally: we, wmask, addr, din from
//    the winner. Idle: sram_we=0, sram_addr=0, wmask=0, din=0; the macro
//    performs a harmless read, and no response is produced.
//  - Read latency 1: a read handshake at edge N gives rsp_valid[id]=1 for
//    exactly the cycle after N, with rsp_dout=sram_dout (passthrough).
//    At most one rsp_valid bit is set per cycle. No response backpressure.
//  - Writes produce no response. Write then read of the same address on
//    consecutive cycles returns the new data. sram_dout is ignored after a
//    write (macro drives X).
//  - rsp_dout is don't-care when rsp_valid==0; the bench must not check it.
// STRUCTURE
//  - sram22_ctrl_pkg: state enum {INIT,RUN}, default width localparams,
//    port-id localparams.
//  - Sub-module sram22_rr_arb2: 2-way round-robin arbiter with valid in,
//    grant out, and the rr_ptr flop. Fill counter, response tag flop and mux
//    stay in the top.
// TESTING  (bench pairs block with the SRAM22 behavioural model)
//  1. Reset, no requests -> sram_we=1 for 64 cycles, addr 0..63, din=0;
//     init_done rises on cycle 65; req_ready=0 throughout.
//  2. Port0 writes 0xA to addr 5 with wmask 2'b11, then reads addr 5 ->
//     rsp_valid=2'b01 one cycle after the read handshake, rsp_dout=0xA.
//  3. Partial mask: write 0xF to addr 9 with wmask 2'b01, then read ->
//     rsp_dout=0x3 (upper half still zero from fill).
//  4. Both ports issue continuous reads of addr 1 / addr 2 -> grants
//     alternate 0,1,0,1; rsp_valid alternates 01,10 with the matching data.
//  5. Reset asserted on fill cycle 30 -> fill restarts at addr 0, and
//     init_done stays 0 for 64 more cycles.
//  6. Reset asserted the cycle after a read handshake -> rsp_valid stays
//     0 next cycle; rr_ptr=0, so port0 wins the first contended grant.

Source files
------------

// File: rtl/sram22_ctrl_pkg.sv
// Shared types and defaults for the SRAM22 port controller.
// State encoding, width defaults and port identifiers.
package sram22_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DATA_WIDTH_D  = 4;
  localparam int ADDR_WIDTH_D  = 6;
  localparam int WMASK_WIDTH_D = 2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram22_rr_arb2.sv
// Two-way round-robin arbiter for the SRAM22 port controller.
// Grant is combinational from valid; the pointer flips after each grant.
module sram22_rr_arb2
  import sram22_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       gnt_id
);

  logic rr_ptr;

  // Pick the winner: lone requester wins, contention goes to rr_ptr.
  always_comb begin
    grant  = 2'b00;
    gnt_id = PORT0;
    if (en) begin
      unique case (valid)
        2'b01:   gnt_id = PORT0;
        2'b10:   gnt_id = PORT1;
        2'b11:   gnt_id = rr_ptr;
        default: gnt_id = PORT0;
      endcase
      if (valid != 2'b00)
        grant = (gnt_id == PORT1) ? 2'b10 : 2'b01;
    end
  end

  // Hand priority to the other port after every grant.
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= PORT0;
    else if (grant != 2'b00)
      rr_ptr <= ~gnt_id;
  end

endmodule

// File: rtl/sram22_port_ctrl.sv
// SRAM22 single-port sequencer: zero-fills the macro after reset,
// then shares the port between two requesters with read responses.
module sram22_port_ctrl
  import sram22_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_D,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_D,
  parameter int WMASK_WIDTH = WMASK_WIDTH_D
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [1:0]               req_we,
  input  logic [2*WMASK_WIDTH-1:0] req_wmask,
  input  logic [2*ADDR_WIDTH-1:0]  req_addr,
  input  logic [2*DATA_WIDTH-1:0]  req_din,
  output logic [1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_dout,
  output logic                     sram_we,
  output logic [WMASK_WIDTH-1:0]   sram_wmask,
  output logic [ADDR_WIDTH-1:0]    sram_addr,
  output logic [DATA_WIDTH-1:0]    sram_din,
  input  logic [DATA_WIDTH-1:0]    sram_dout
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [1:0]            grant;
  logic                  gnt_id;
  logic                  rsp_pend;
  logic                  rsp_id;

  sram22_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (state == RUN),
    .valid  (req_valid),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  // State register and fill address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT)
        init_cnt <= init_cnt + 1'b1;
    end
  end

  // Leave INIT after the last address has been written.
  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == LAST)
      state_nxt = RUN;
  end

  // Macro port mux: fill writer, granted requester, or idle read.
  always_comb begin
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (state == INIT) begin
      sram_we    = 1'b1;
      sram_wmask = '1;
      sram_addr  = init_cnt;
    end else if (grant != 2'b00) begin
      if (gnt_id == PORT1) begin
        sram_we    = req_we[1];
        sram_wmask = req_wmask[WMASK_WIDTH +: WMASK_WIDTH];
        sram_addr  = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
        sram_din   = req_din[DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sram_we    = req_we[0];
        sram_wmask = req_wmask[0 +: WMASK_WIDTH];
        sram_addr  = req_addr[0 +: ADDR_WIDTH];
        sram_din   = req_din[0 +: DATA_WIDTH];
      end
    end
  end

  // Tag a granted read so its data is routed next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend <= 1'b0;
      rsp_id   <= PORT0;
    end else begin
      rsp_pend <= (grant != 2'b00) && !sram_we;
      rsp_id   <= gnt_id;
    end
  end

  assign req_ready = grant;
  assign init_done = (state == RUN);
  assign rsp_dout  = sram_dout;
  assign rsp_valid = !rsp_pend ? 2'b00 :
                     (rsp_id == PORT1) ? 2'b10 : 2'b01;

endmodule

// File: tb/tb_sram22_port_ctrl.sv
// Bench for sram22_port_ctrl with a behavioural SRAM22 macro model.
// Read expectations go into a queue; a monitor pops them on rsp_valid.
module tb_sram22_port_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_we;
  logic [3:0] req_wmask;
  logic [11:0] req_addr;
  logic [7:0] req_din;
  logic [1:0] rsp_valid;
  logic [3:0] rsp_dout;
  logic       sram_we;
  logic [1:0] sram_wmask;
  logic [5:0] sram_addr;
  logic [3:0] sram_din;
  logic [3:0] sram_dout;

  logic [3:0] mem [64];
  logic [4:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram22_port_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_din    (req_din),
    .rsp_valid  (rsp_valid),
    .rsp_dout   (rsp_dout),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // SRAM22 model: masked write, registered read, X out after a write.
  always @(posedge clk) begin
    if (sram_we) begin
      for (int k = 0; k < 2; k++)
        if (sram_wmask[k])
          mem[sram_addr][k*2 +: 2] <= sram_din[k*2 +: 2];
      sram_dout <= 'x;
    end else begin
      sram_dout <= mem[sram_addr];
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid !== 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected rsp_valid", 32'(rsp_valid), 0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), e[4] ? 2 : 1);
        chk("rsp_dout", 32'(rsp_dout), 32'(e[3:0]));
      end
    end
  end

  task automatic set_port(int p, bit we, logic [1:0] m,
                          logic [5:0] a, logic [3:0] d);
    req_we[p]          = we;
    req_wmask[p*2 +: 2] = m;
    req_addr[p*6 +: 6]  = a;
    req_din[p*4 +: 4]   = d;
  endtask

  task automatic do_req(int p, bit we, logic [1:0] m, logic [5:0] a,
                        logic [3:0] d, logic [3:0] exp);
    bit ok = 0;
    set_port(p, we, m, a, d);
    req_valid[p] = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      #1;
      if (req_ready[p]) begin
        ok = 1;
        if (!we) exp_q.push_back({p[0], exp});
      end
      @(negedge clk);
    end
    req_valid[p] = 1'b0;
    chk("handshake", 32'(ok), 1);
  endtask

  task automatic fill_check(int n, bit full);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("fill we", 32'(sram_we), 1);
      chk("fill addr", 32'(sram_addr), i);
      chk("fill din", 32'(sram_din), 0);
      chk("fill wmask", 32'(sram_wmask), 3);
      chk("fill ready", 32'(req_ready), 0);
      chk("fill init_done", 32'(init_done), 0);
      @(negedge clk);
    end
    if (full) begin
      req_valid = 2'b00;
      #1;
      chk("init_done", 32'(init_done), 1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_we = '0;
    req_wmask = '0;
    req_addr = '0;
    req_din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11;
    fill_check(64, 1);

    do_req(0, 1, 2'b11, 6'd5, 4'hA, 4'h0);
    do_req(0, 0, 2'b11, 6'd5, 4'h0, 4'hA);
    do_req(0, 1, 2'b01, 6'd9, 4'hF, 4'h0);
    do_req(0, 0, 2'b11, 6'd9, 4'h0, 4'h3);

    do_req(0, 1, 2'b11, 6'd1, 4'h6, 4'h0);
    do_req(1, 1, 2'b11, 6'd2, 4'h9, 4'h0);
    set_port(0, 0, 2'b11, 6'd1, 4'h0);
    set_port(1, 0, 2'b11, 6'd2, 4'h0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr grant", 32'(req_ready), (k % 2) ? 2 : 1);
      exp_q.push_back((k % 2) ? 5'h19 : 5'h06);
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (2) @(negedge clk);

    req_valid = 2'b11;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fill_check(30, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fill_check(64, 1);

    set_port(0, 0, 2'b11, 6'd5, 4'h0);
    req_valid = 2'b01;
    #1;
    chk("read ready", 32'(req_ready), 1);
    exp_q.push_back(5'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rsp dropped", 32'(rsp_valid), 0);
    rst = 1'b0;
    req_valid = 2'b11;
    fill_check(64, 0);
    #1;
    chk("init_done again", 32'(init_done), 1);
    set_port(1, 0, 2'b11, 6'd7, 4'h0);
    req_valid = 2'b11;
    chk("rr after reset", 32'(req_ready), 1);
    exp_q.push_back(5'h00);
    @(negedge clk);
    req_valid = 2'b00;

    repeat (3) @(negedge clk);
    chk("queue empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
